// File: rtl/display_sequencer_pkg.sv
// Shared definitions for the debug display source sequencer: mux select
// codes and the sequencer FSM state encoding.
package display_sequencer_pkg;

  localparam logic [2:0] SEL_BLANK   = 3'd0;
  localparam logic [2:0] SEL_PC      = 3'd1;
  localparam logic [2:0] SEL_INSTR   = 3'd2;
  localparam logic [2:0] SEL_ALU_A   = 3'd3;
  localparam logic [2:0] SEL_ALU_B   = 3'd4;
  localparam logic [2:0] SEL_ALU_OUT = 3'd5;
  localparam logic [2:0] SEL_SERIAL  = 3'd6;

  typedef enum logic [1:0] {
    BLANK  = 2'd0,
    AUTO   = 2'd1,
    MANUAL = 2'd2
  } state_e;

endpackage

// File: rtl/display_sequencer_btn_debounce.sv
// Push-button conditioner: two-flop synchronizer, stability-count debounce,
// and a registered one-cycle pulse on each accepted press.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic pulse_out
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             db_q, db_d;
  logic             db_prev_q, db_prev_d;
  logic             pulse_q, pulse_d;

  always_comb begin
    s1_d      = btn_in;
    s2_d      = s1_q;
    db_d      = db_q;
    cnt_d     = cnt_q;
    db_prev_d = db_q;
    pulse_d   = db_q & ~db_prev_q;
    // Any return to the accepted level restarts the stability window
    if (s2_q == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      db_d  = s2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      cnt_q     <= '0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      cnt_q     <= cnt_d;
      db_q      <= db_d;
      db_prev_q <= db_prev_d;
      pulse_q   <= pulse_d;
    end
  end

  assign pulse_out = pulse_q;

endmodule

// File: rtl/display_sequencer.sv
// Debug display source sequencer: blanks, auto-rotates on a dwell timer,
// or steps one source per debounced button press.
module display_sequencer
  import display_sequencer_pkg::*;
#(
  parameter int DWELL_CYCLES    = 50000000,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int FIRST_SEL       = 1,
  parameter int LAST_SEL        = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       mode_auto,
  input  logic       pause,
  input  logic       step_btn,
  output logic [2:0] sel_out,
  output logic       frame_done,
  output logic       auto_active
);

  localparam int DWELL_W = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(DWELL_CYCLES - 1);
  localparam logic [2:0] FIRST_CODE = 3'(FIRST_SEL);
  localparam logic [2:0] LAST_CODE  = 3'(LAST_SEL);

  function automatic logic [2:0] next_sel(input logic [2:0] cur);
    return (cur == LAST_CODE) ? FIRST_CODE : cur + 3'd1;
  endfunction

  logic               step_pulse;
  state_e             state_q, state_d;
  logic [2:0]         sel_q, sel_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               frame_q, frame_d;
  logic               auto_q, auto_d;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk      (clk),
    .rst      (rst),
    .btn_in   (step_btn),
    .pulse_out(step_pulse)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    dwell_d = dwell_q;
    frame_d = 1'b0;
    if (!enable) begin
      state_d = BLANK;
      sel_d   = SEL_BLANK;
      dwell_d = '0;
    end else begin
      case (state_q)
        BLANK: begin
          sel_d   = FIRST_CODE;
          dwell_d = '0;
          state_d = mode_auto ? AUTO : MANUAL;
        end
        AUTO: begin
          // A mode change swallows a coincident dwell expiry
          if (!mode_auto) begin
            state_d = MANUAL;
            dwell_d = '0;
          end else if (pause) begin
            dwell_d = dwell_q;
          end else if (dwell_q == DWELL_MAX) begin
            dwell_d = '0;
            sel_d   = next_sel(sel_q);
            frame_d = (sel_q == LAST_CODE);
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
        end
        MANUAL: begin
          if (mode_auto) begin
            state_d = AUTO;
            dwell_d = '0;
          end else if (step_pulse) begin
            sel_d   = next_sel(sel_q);
            frame_d = (sel_q == LAST_CODE);
          end
        end
        default: begin
          state_d = BLANK;
          sel_d   = SEL_BLANK;
          dwell_d = '0;
        end
      endcase
    end
    auto_d = (state_d == AUTO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BLANK;
      sel_q   <= SEL_BLANK;
      dwell_q <= '0;
      frame_q <= 1'b0;
      auto_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      dwell_q <= dwell_d;
      frame_q <= frame_d;
      auto_q  <= auto_d;
    end
  end

  assign sel_out     = sel_q;
  assign frame_done  = frame_q;
  assign auto_active = auto_q;

endmodule

// File: doc/display_sequencer.md
Name: display_sequencer

Overview:
- Drives the 3-bit source select of the debug display mux (codes 1..6: PC, instruction, ALU A, ALU B, ALU result, serial byte; 0 = blank).
- Auto mode rotates through the sources on a dwell timer. Manual mode advances one source per debounced push-button press.
- Sits between board switches/buttons and the display mux select input.

Parameters:
- DWELL_CYCLES, 50000000, clock cycles each source is shown in auto mode (≥2)
- DEBOUNCE_CYCLES, 500000, cycles step_btn must be stable before a level change is accepted (≥2)
- FIRST_SEL, 1, first select code in the rotation
- LAST_SEL, 6, last select code in the rotation (FIRST_SEL < LAST_SEL ≤ 6)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- enable  in  1  0 = blank display (select 0)
- mode_auto  in  1  1 = auto rotate, 0 = manual step
- pause  in  1  auto mode only: freeze dwell counter and select
- step_btn  in  1  raw, asynchronous push-button
- sel_out  out  3  select code to display mux
- frame_done  out  1  one-cycle pulse on wrap LAST_SEL→FIRST_SEL
- auto_active  out  1  high while in AUTO state

Behaviour:
- Reset (async assert): state=BLANK, sel_out=0, frame_done=0, auto_active=0. Dwell counter, debounce counter, sync flops and debounced level all 0.
- Button path:
  - step_btn → 2-flop synchronizer (s1, s2).
  - Debounce counter: if s2==db, cnt←0. Else if cnt==DEBOUNCE_CYCLES-1, db←s2 and cnt←0. Else cnt++.
  - step_pulse is registered: step_pulse←db & ~db_d, where db_d is db delayed one cycle.
  - With step_btn held high from edge 1, step_pulse is high for exactly one cycle after edge DEBOUNCE_CYCLES+3.
  - sel_out advances at edge DEBOUNCE_CYCLES+4.
  - Release generates no pulse. Glitches shorter than DEBOUNCE_CYCLES produce no pulse.
- FSM states: BLANK, AUTO, MANUAL. All outputs are registered.
  - BLANK: sel_out=0, dwell cnt=0.
    - enable=1 → sel_out←FIRST_SEL.
    - Next state is AUTO if mode_auto=1, else MANUAL.
  - AUTO: auto_active=1.
    - If pause=1: hold the counter and sel_out.
    - Else if dwell==DWELL_CYCLES-1: dwell←0 and sel_out advances.
    - Else dwell++.
    - Each code is therefore held for exactly DWELL_CYCLES unpaused cycles.
    - mode_auto=0 → MANUAL, dwell←0, sel_out held.
  - MANUAL: step_pulse advances sel_out; pause is ignored.
    - mode_auto=1 → AUTO, dwell←0, sel_out held, fresh full dwell.
- Advance rule: sel_out==LAST_SEL → FIRST_SEL with frame_done=1 that cycle. Otherwise sel_out+1.
- sel_out never takes 7 or any value outside {0, FIRST_SEL..LAST_SEL}.
- Priority, same cycle:
  - enable=0 beats everything: next state BLANK, sel_out←0, dwell←0, frame_done←0.
  - Mode change beats step_pulse and dwell expiry; the step is dropped and no advance occurs.
- The debounce path runs in all states. Presses in BLANK or AUTO are consumed and discarded.
- Re-enable always restarts at FIRST_SEL.
- Reset mid-dwell or mid-debounce: immediate return to reset values; no pulse is emitted.

Decomposition:
- Shared package:
  - select code constants SEL_BLANK=0, SEL_PC=1, SEL_INSTR=2, SEL_ALU_A=3, SEL_ALU_B=4, SEL_ALU_OUT=5, SEL_SERIAL=6
  - FSM state enum {BLANK, AUTO, MANUAL}
- Sub-module btn_debounce (synchronizer + debounce + rising-edge pulse), parameterised by DEBOUNCE_CYCLES. It can be reused for other board buttons.

Test Plan (DWELL_CYCLES=4, DEBOUNCE_CYCLES=3, FIRST_SEL=1, LAST_SEL=6):
- Reset then enable=1, mode_auto=1 → sel_out sequence 1×4, 2×4, …, 6×4, then 1. frame_done high exactly on the 6→1 edge; auto_active=1.
- Auto at sel_out=3 after 2 dwell cycles, pause=1 for 10 cycles, then 0 → sel_out stays 3; advances to 4 exactly 2 unpaused cycles later.
- Manual: step_btn high from edge 1 for 10 cycles → step_pulse high after edge 6; sel_out 1→2 at edge 7, with no further advance. Then a 2-cycle glitch on step_btn → no change.
- Manual at sel_out=6, one valid press → sel_out=1 and frame_done pulse. Mode change coincident with step_pulse → no advance; AUTO starts a full 4-cycle dwell.
- Auto mid-dwell at sel_out=5, enable=0 → next edge sel_out=0, state BLANK. enable=1 → sel_out=1 with a full dwell.
- Assert rst asynchronously mid-dwell and mid-debounce → sel_out=0, frame_done=0, auto_active=0 immediately, before the next clock edge. No step pulse after release.
